// File: rtl/syn_gpu_div_client_if.sv
// Signal bundle for the GPU divide client.
// It carries the local command/response handshake and the mulberry divide bus lines.
//   master : the divide client. It drives cmd_ready, the rsp_* signals and the div_req_* lines.
//   slave  : the environment (the local sub-block and the divider). It drives the rest.
// Local command : cmd_valid, cmd_ready, cmd_dividend[15:0], cmd_divisor[15:0]
// Local result  : rsp_valid, rsp_ready, rsp_quot[15:0], rsp_rem[15:0], rsp_err[1:0]
// Mulberry bus  : div_req_mid, div_req_data[31:0], div_busy, div_rsp_mid, div_rsp_data[31:0]
interface syn_gpu_div_client_if #(
    parameter int unsigned MID_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [15:0]      cmd_dividend;
    logic [15:0]      cmd_divisor;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_quot;
    logic [15:0]      rsp_rem;
    logic [1:0]       rsp_err;

    logic [MID_W-1:0] div_req_mid;
    logic [31:0]      div_req_data;
    logic             div_busy;
    logic [MID_W-1:0] div_rsp_mid;
    logic [31:0]      div_rsp_data;

    modport master (
        input  cmd_valid, cmd_dividend, cmd_divisor, rsp_ready,
               div_busy, div_rsp_mid, div_rsp_data,
        output cmd_ready, rsp_valid, rsp_quot, rsp_rem, rsp_err,
               div_req_mid, div_req_data
    );

    modport slave (
        output cmd_valid, cmd_dividend, cmd_divisor, rsp_ready,
               div_busy, div_rsp_mid, div_rsp_data,
        input  cmd_ready, rsp_valid, rsp_quot, rsp_rem, rsp_err,
               div_req_mid, div_req_data
    );
endinterface

// File: rtl/syn_gpu_div_client.sv
// Mulberry bus initiator for the GPU divide service.
// The client takes one 16b/16b divide command at a time.
// It issues a single-cycle tagged request on the div lines, then waits for the
// matching response and returns the quotient and remainder to the local client.
// A zero divisor is answered locally with no bus request.
// If no response arrives within TMO_CYC cycles, the client returns a timeout error.
// Ports:
//   clk_ir     : system clock
//   rst_sync_l : asynchronous active-low reset
//   bus        : syn_gpu_div_client_if.master (command, result and mulberry div lines)
// rsp_err encoding: 0 = ok, 1 = divide-by-zero, 2 = timeout.
module syn_gpu_div_client #(
    parameter int unsigned       MID_W    = 4,
    parameter logic [MID_W-1:0]  MID_IDLE = '0,
    parameter logic [MID_W-1:0]  MY_MID   = MID_W'(1),
    parameter int unsigned       TMO_W    = 8,
    parameter int unsigned       TMO_CYC  = 200
) (
    input  logic                 clk_ir,
    input  logic                 rst_sync_l,
    syn_gpu_div_client_if.master bus
);

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_DIV0 = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_DONE
    } state_t;

    state_t           state, state_nxt;

    logic [15:0]      dvd_q, dvd_nxt;
    logic [15:0]      dvs_q, dvs_nxt;
    logic [TMO_W-1:0] tmo_q, tmo_nxt;

    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic [15:0]      quot_q, quot_nxt;
    logic [15:0]      rem_q, rem_nxt;
    logic [1:0]       err_q, err_nxt;
    logic [MID_W-1:0] req_mid_q, req_mid_nxt;
    logic [31:0]      req_data_q, req_data_nxt;

    logic             rsp_match;

    assign rsp_match = (bus.div_rsp_mid == MY_MID);

    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        dvd_nxt      = dvd_q;
        dvs_nxt      = dvs_q;
        quot_nxt     = quot_q;
        rem_nxt      = rem_q;
        err_nxt      = err_q;
        req_mid_nxt  = MID_IDLE;     // the request is a one-clock pulse
        req_data_nxt = req_data_q;   // data lingers after the pulse
        tmo_nxt      = '0;

        unique case (state)
            S_IDLE: begin
                // cmd_ready is registered, so it gates acceptance.
                // This keeps the cycle right after reset release from taking a command.
                if (bus.cmd_valid && cmd_ready_q) begin
                    dvd_nxt = bus.cmd_dividend;
                    dvs_nxt = bus.cmd_divisor;
                    if (bus.cmd_divisor == 16'd0) begin
                        quot_nxt  = '1;
                        rem_nxt   = bus.cmd_dividend;
                        err_nxt   = ERR_DIV0;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!bus.div_busy) begin
                    req_mid_nxt  = MY_MID;
                    req_data_nxt = {dvd_q, dvs_q};
                    state_nxt    = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                // A match takes priority over a timeout in the same cycle.
                if (rsp_match) begin
                    quot_nxt  = bus.div_rsp_data[31:16];
                    rem_nxt   = bus.div_rsp_data[15:0];
                    err_nxt   = ERR_OK;
                    state_nxt = S_DONE;
                end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
                    quot_nxt  = '0;
                    rem_nxt   = '0;
                    err_nxt   = ERR_TMO;
                    state_nxt = S_DONE;
                end else begin
                    tmo_nxt = tmo_q + TMO_W'(1);
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // The handshake flags are derived from the next state.
    // Because of that, they change on the same edge as the FSM.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            tmo_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            err_q       <= ERR_OK;
            req_mid_q   <= MID_IDLE;
            req_data_q  <= '0;
        end else begin
            dvd_q       <= dvd_nxt;
            dvs_q       <= dvs_nxt;
            tmo_q       <= tmo_nxt;
            cmd_ready_q <= (state_nxt == S_IDLE);
            rsp_valid_q <= (state_nxt == S_DONE);
            quot_q      <= quot_nxt;
            rem_q       <= rem_nxt;
            err_q       <= err_nxt;
            req_mid_q   <= req_mid_nxt;
            req_data_q  <= req_data_nxt;
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_quot     = quot_q;
    assign bus.rsp_rem      = rem_q;
    assign bus.rsp_err      = err_q;
    assign bus.div_req_mid  = req_mid_q;
    assign bus.div_req_data = req_data_q;

endmodule

// File: tb/tb_syn_gpu_div_client.sv
// Self-checking bench for syn_gpu_div_client.
// Expected results come from plain integer division plus the client's error rules.
// A monitor checks bus protocol and result values on every cycle.
// Directed scenarios pin the model with literal values.
module tb_syn_gpu_div_client;

    localparam int unsigned MID_W    = 4;
    localparam logic [3:0]  MID_IDLE = 4'd0;
    localparam logic [3:0]  MY_MID   = 4'd1;
    localparam logic [3:0]  FOREIGN  = 4'd2;
    localparam int unsigned TMO_CYC  = 200;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic [1:0]  e;
    } res_t;

    logic clk_ir     = 1'b0;
    logic rst_sync_l = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    res_t        exp_q[$];
    logic [31:0] req_q[$];

    syn_gpu_div_client_if #(.MID_W(MID_W)) bus ();

    syn_gpu_div_client #(
        .MID_W   (MID_W),
        .MID_IDLE(MID_IDLE),
        .MY_MID  (MY_MID),
        .TMO_W   (8),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk_ir    (clk_ir),
        .rst_sync_l(rst_sync_l),
        .bus       (bus)
    );

    always #5 clk_ir = ~clk_ir;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_ir);
        #1;
    endtask

    // ---------------- per-cycle monitor ----------------
    logic       prev_valid, prev_ready, prev_busy;
    logic [3:0] prev_mid;
    res_t       cur;

    always @(negedge clk_ir) begin
        if (!rst_sync_l) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_busy  = 1'b0;
            prev_mid   = MID_IDLE;
        end else begin
            chk("ready_valid_excl", 32'(bus.cmd_ready & bus.rsp_valid), 32'd0);
            if (bus.div_req_mid == MY_MID) begin
                chk("req_pulse", 32'(prev_mid), 32'(MID_IDLE));
                chk("req_after_busy", 32'(prev_busy), 32'd0);
                if (req_q.size() == 0)
                    chk("req_unexpected", 32'(bus.div_req_mid), 32'(MID_IDLE));
                else
                    chk("req_data", bus.div_req_data, req_q.pop_front());
            end else begin
                chk("req_mid_idle", 32'(bus.div_req_mid), 32'(MID_IDLE));
            end
            if (bus.rsp_valid && !prev_valid) begin
                if (exp_q.size() == 0)
                    chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                else
                    cur = exp_q.pop_front();
            end
            if (bus.rsp_valid) begin
                chk("rsp_quot", 32'(bus.rsp_quot), 32'(cur.q));
                chk("rsp_rem",  32'(bus.rsp_rem),  32'(cur.r));
                chk("rsp_err",  32'(bus.rsp_err),  32'(cur.e));
            end
            if (prev_valid && !bus.rsp_valid)
                chk("rsp_release", 32'(prev_ready), 32'd1);
            if (prev_valid && !prev_ready)
                chk("rsp_hold", 32'(bus.rsp_valid), 32'd1);
            prev_valid = bus.rsp_valid;
            prev_ready = bus.rsp_ready;
            prev_busy  = bus.div_busy;
            prev_mid   = bus.div_req_mid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_quot"},  32'(bus.rsp_quot),  32'd0);
        chk({tag, "_rsp_rem"},   32'(bus.rsp_rem),   32'd0);
        chk({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
        chk({tag, "_req_mid"},   32'(bus.div_req_mid), 32'(MID_IDLE));
        chk({tag, "_req_data"},  bus.div_req_data,   32'd0);
    endtask

    // A full transaction. The timeout case is selected by tmo.
    // The first result and the request seen are returned so that
    // directed tests can pin them with literal values.
    task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                          input int busy_n, input int delay, input int noise,
                          input int backp, input bit tmo,
                          output logic [31:0] req_seen, output res_t res_seen);
        int   k;
        res_t e;
        req_seen = '0;
        k = 0;
        while (!bus.cmd_ready && k < 50) begin
            step();
            k++;
        end
        chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid    = 1'b1;
        bus.cmd_dividend = a;
        bus.cmd_divisor  = b;
        bus.div_busy     = (busy_n > 0);
        if (b == 16'd0) begin
            e.q = 16'hFFFF; e.r = a; e.e = 2'd1;
            exp_q.push_back(e);
        end else begin
            req_q.push_back({a, b});
        end
        step();
        bus.cmd_valid    = 1'b0;
        bus.cmd_dividend = 16'($urandom);
        bus.cmd_divisor  = 16'($urandom);
        chk("cmd_ready_drop", 32'(bus.cmd_ready), 32'd0);
        if (b == 16'd0) begin
            chk("div0_latency", 32'(bus.rsp_valid), 32'd1);
        end else begin
            for (int i = 0; i < busy_n; i++) begin
                chk("busy_no_req", 32'(bus.div_req_mid), 32'(MID_IDLE));
                bus.div_rsp_mid  = ($urandom_range(0, 1) == 1) ? MY_MID : MID_IDLE;
                bus.div_rsp_data = $urandom;
                step();
            end
            bus.div_busy    = 1'b0;
            bus.div_rsp_mid = MID_IDLE;
            step();
            chk("req_issue_latency", 32'(bus.div_req_mid), 32'(MY_MID));
            req_seen = bus.div_req_data;
            if (tmo) begin
                e.q = 16'd0; e.r = 16'd0; e.e = 2'd2;
                exp_q.push_back(e);
                k = 0;
                while (!bus.rsp_valid && k < 300) begin
                    bus.div_rsp_mid  = (k < noise) ? FOREIGN : MID_IDLE;
                    bus.div_rsp_data = $urandom;
                    step();
                    k++;
                end
                bus.div_rsp_mid = MID_IDLE;
                chk("timeout_cycles", 32'(k), 32'(TMO_CYC));
            end else begin
                for (int i = 0; i < delay; i++) begin
                    bus.div_rsp_mid  = (i < noise) ? FOREIGN : MID_IDLE;
                    bus.div_rsp_data = $urandom;
                    step();
                    chk("wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
                end
                e.q = a / b; e.r = a % b; e.e = 2'd0;
                exp_q.push_back(e);
                bus.div_rsp_mid  = MY_MID;
                bus.div_rsp_data = {e.q, e.r};
                step();
                bus.div_rsp_mid = MID_IDLE;
                chk("match_latency", 32'(bus.rsp_valid), 32'd1);
            end
        end
        res_seen.q = bus.rsp_quot;
        res_seen.r = bus.rsp_rem;
        res_seen.e = bus.rsp_err;
        for (int i = 0; i < backp; i++) begin
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            bus.div_rsp_mid  = ($urandom_range(0, 1) == 1) ? MY_MID : MID_IDLE;
            bus.div_rsp_data = $urandom;
            step();
        end
        bus.div_rsp_mid = MID_IDLE;
        bus.rsp_ready   = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("rsp_cleared", 32'(bus.rsp_valid), 32'd0);
        chk("cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    endtask

    // Drive a stale MY_MID response while idle; it must produce nothing.
    task automatic stale_idle();
        bus.div_rsp_mid  = MY_MID;
        bus.div_rsp_data = $urandom;
        step();
        bus.div_rsp_mid = MID_IDLE;
        chk("stale_dropped", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rq;
        res_t        rs;
        logic [15:0] a, b;
        bus.cmd_valid    = 1'b0;
        bus.cmd_dividend = '0;
        bus.cmd_divisor  = '0;
        bus.rsp_ready    = 1'b0;
        bus.div_busy     = 1'b0;
        bus.div_rsp_mid  = MID_IDLE;
        bus.div_rsp_data = '0;

        step();
        step();
        check_reset_vals("reset");
        rst_sync_l = 1'b1;
        chk("ready_at_release", 32'(bus.cmd_ready), 32'd0);
        step();
        chk("ready_after_release", 32'(bus.cmd_ready), 32'd1);

        // basic divide
        do_div(16'd100, 16'd7, 0, 2, 1, 0, 1'b0, rq, rs);
        chk("basic_req_data", rq, 32'h00640007);
        chk("basic_quot", 32'(rs.q), 32'd14);
        chk("basic_rem",  32'(rs.r), 32'd2);
        chk("basic_err",  32'(rs.e), 32'd0);

        // busy stall
        do_div(16'd500, 16'd3, 10, 1, 0, 0, 1'b0, rq, rs);
        chk("stall_req_data", rq, 32'h01F40003);
        chk("stall_quot", 32'(rs.q), 32'd166);
        chk("stall_rem",  32'(rs.r), 32'd2);

        // divide by zero with backpressure
        do_div(16'd1234, 16'd0, 0, 0, 0, 5, 1'b0, rq, rs);
        chk("div0_quot", 32'(rs.q), 32'hFFFF);
        chk("div0_rem",  32'(rs.r), 32'd1234);
        chk("div0_err",  32'(rs.e), 32'd1);

        // foreign MIDs only, ending in a timeout, then a stale response, then normal operation
        do_div(16'd77, 16'd5, 0, 0, 150, 0, 1'b1, rq, rs);
        chk("tmo_quot", 32'(rs.q), 32'd0);
        chk("tmo_rem",  32'(rs.r), 32'd0);
        chk("tmo_err",  32'(rs.e), 32'd2);
        stale_idle();
        do_div(16'd65535, 16'd256, 0, 0, 0, 1, 1'b0, rq, rs);
        chk("after_tmo_quot", 32'(rs.q), 32'd255);
        chk("after_tmo_rem",  32'(rs.r), 32'd255);

        // randomized transactions
        for (int n = 0; n < 24; n++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 16'd0 :
                (($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 20)) : 16'($urandom));
            do_div(a, b, $urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 4),
                   $urandom_range(0, 3), ($urandom_range(0, 7) == 0), rq, rs);
            if ($urandom_range(0, 2) == 0) stale_idle();
        end

        // reset during WAIT_RSP
        while (!bus.cmd_ready) step();
        bus.cmd_valid    = 1'b1;
        bus.cmd_dividend = 16'd300;
        bus.cmd_divisor  = 16'd9;
        req_q.push_back({16'd300, 16'd9});
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        step();
        #2;
        rst_sync_l = 1'b0;
        #1;
        check_reset_vals("midop_reset");
        exp_q.delete();
        req_q.delete();
        step();
        rst_sync_l = 1'b1;
        bus.div_rsp_mid  = MY_MID;
        bus.div_rsp_data = {16'd33, 16'd3};
        step();
        bus.div_rsp_mid = MID_IDLE;
        chk("post_reset_no_valid", 32'(bus.rsp_valid), 32'd0);
        chk("post_reset_ready", 32'(bus.cmd_ready), 32'd1);
        step();
        chk("post_reset_still_idle", 32'(bus.rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/syn_gpu_div_client.md
Name: syn_gpu_div_client

Overview:
- Mulberry bus initiator for the GPU divide service, owned by one GPU sub-block (e.g. the line/slope engine) that needs 16b/16b quotients.
- Accepts a local divide command over a valid/ready handshake and issues a single-cycle request on the mulberry div lines.
- Waits for the divider's tagged response, then returns quotient and remainder to the local client over valid/ready.
- Adds a divide-by-zero short-circuit and a response timeout.

Parameters:
- MID_W, 4, width of mulberry MID codes (matches mid_t in syn_gpu_pkg).
- MID_IDLE, 0, MID code meaning "no request/response".
- MY_MID, 1, MID this client places on requests and matches on responses; must not equal MID_IDLE.
- TMO_W, 8, width of the response timeout counter.
- TMO_CYC, 200, cycles in WAIT_RSP before a timeout error is returned.

Ports:
- clk_ir  in  1  system clock; single clock domain.
- rst_sync_l  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  local divide command valid.
- cmd_ready  out  1  client can accept a command (high only in IDLE).
- cmd_dividend  in  16  dividend.
- cmd_divisor  in  16  divisor.
- rsp_valid  out  1  result valid; held until rsp_ready.
- rsp_ready  in  1  local consumer accepts result.
- rsp_quot  out  16  quotient.
- rsp_rem  out  16  remainder.
- rsp_err  out  2  0=ok, 1=divide-by-zero, 2=timeout.
- div_req_mid  out  MID_W  mulberry request MID.
- div_req_data  out  32  [31:16]=dividend, [15:0]=divisor.
- div_busy  in  1  divider busy.
- div_rsp_mid  in  MID_W  mulberry response MID.
- div_rsp_data  in  32  [31:16]=quotient, [15:0]=remainder.

Behaviour:
- Reset values: cmd_ready=0 during reset, 1 from the first cycle after release. rsp_valid=0, rsp_quot=0, rsp_rem=0, rsp_err=0, div_req_mid=MID_IDLE, div_req_data=0, FSM=IDLE, timeout counter=0.
- Reset asserted mid-operation aborts immediately; any later response carrying MY_MID is ignored because the FSM is in IDLE.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE:
  - cmd_ready=1. On cmd_valid, latch dividend and divisor.
  - If divisor==0: go to DONE with quot=16'hFFFF, rem=dividend, err=1. No bus request is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - While div_busy=1, hold div_req_mid=MID_IDLE and wait.
  - On the first cycle div_busy=0, register div_req_mid=MY_MID and div_req_data={dividend,divisor} and go to WAIT_RSP.
  - The request is visible on the bus for exactly one clock. The next cycle div_req_mid returns to MID_IDLE; div_req_data holds its value.
- WAIT_RSP:
  - The timeout counter increments each cycle.
  - When div_rsp_mid==MY_MID: capture quot=div_rsp_data[31:16], rem=div_rsp_data[15:0], err=0, clear the counter, go to DONE.
  - Responses with any other MID are ignored.
  - When the counter reaches TMO_CYC-1 without a match: quot=0, rem=0, err=2, go to DONE.
  - If a match and the timeout occur in the same cycle, the match wins.
- DONE:
  - rsp_valid=1; quot, rem and err stay stable.
  - On rsp_ready=1, rsp_valid clears the next cycle and the FSM returns to IDLE. cmd_ready rises in that same cycle.
- Latency: zero-divisor command to rsp_valid is 1 cycle. Issued command (div_busy=0) to the bus request is 1 cycle. Response match to rsp_valid is 1 cycle.
- Only one command is outstanding at a time. cmd_ready=0 in ISSUE, WAIT_RSP and DONE.
- A stale response for MY_MID arriving while the FSM is in IDLE, ISSUE or DONE is dropped.

Test Plan:
- Basic divide: cmd 100/7 with div_busy=0 -> div_req_mid=MY_MID for 1 cycle with data 32'h00640007; after the responder returns MY_MID with data 32'h000E0002 -> rsp_valid, quot=14, rem=2, err=0.
- Busy stall: hold div_busy=1 for 10 cycles after cmd 500/3 -> no request during those cycles; request appears 1 cycle after busy falls; result quot=166, rem=2.
- Divide by zero: cmd 1234/0 -> no bus activity; rsp_valid 1 cycle later with quot=FFFF, rem=1234, err=1.
- Foreign MID and timeout: responder returns only MID=2 -> ignored; after TMO_CYC=200 cycles in WAIT_RSP -> rsp_valid with err=2. A later MY_MID response is dropped and the next command works normally.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0. Raise rsp_ready -> IDLE next cycle.
- Reset mid-op: assert rst_sync_l=0 during WAIT_RSP -> all outputs return to reset values asynchronously. A post-reset MY_MID response is ignored and rsp_valid stays 0.
